score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_pkg.sv | 33 +++
 rtl/score_keeper_if.sv | 35 +++
 rtl/score_keeper_bcd_digit_inc.sv | 26 ++
 rtl/score_keeper.sv | 189 ++++++++++++++++++
 tb/tb_score_keeper.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_keeper_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : score_keeper_pkg                                            |
// | Purpose  : Shared glyph codes, slot map bases and FSM state encoding   |
// |            for the score keeper and its renderer-facing interface.     |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package score_keeper_pkg;

  // Glyph codes understood by the score renderer; 0-9 are plain digits.
  localparam logic [3:0] GLYPH_H     = 4'd10;
  localparam logic [3:0] GLYPH_I     = 4'd11;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  // Fixed part of the slot map. The score field starts right after the
  // hi-score field, so its base depends on DIGITS (see slot_score_base).
  localparam logic [3:0] SLOT_H       = 4'd0;
  localparam logic [3:0] SLOT_I       = 4'd1;
  localparam logic [3:0] SLOT_HI_BASE = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  function automatic logic [3:0] slot_score_base(input int digits);
    return 4'(int'(SLOT_HI_BASE) + digits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_keeper_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : score_keeper_if                                             |
// | Purpose  : Game-event and renderer signals of the score keeper.        |
// | Ports    : master drives game_tick, run, game_over, restart, slot;     |
// |            slave (the score keeper) drives glyph, score, hi_score,     |
// |            flash.                                                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface score_keeper_if #(
  parameter int DIGITS = 5
) ();

  logic                  game_tick;
  logic                  run;
  logic                  game_over;
  logic                  restart;
  logic [3:0]            slot;
  logic [3:0]            glyph;
  logic [4*DIGITS-1:0]   score;
  logic [4*DIGITS-1:0]   hi_score;
  logic                  flash;

  modport master (
    output game_tick, run, game_over, restart, slot,
    input  glyph, score, hi_score, flash
  );

  modport slave (
    input  game_tick, run, game_over, restart, slot,
    output glyph, score, hi_score, flash
  );

endinterface
`default_nettype wire

// File: rtl/score_keeper_bcd_digit_inc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bcd_digit_inc                                               |
// | Purpose  : One BCD digit of a ripple incrementer (9 -> 0 with carry).  |
// | Ports    : i_digit  in  4  current digit                               |
// |            i_carry  in  1  increment request from lower digit          |
// |            o_digit  out 4  next digit                                  |
// |            o_carry  out 1  carry to next higher digit                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module bcd_digit_inc (
  input  logic [3:0] i_digit,
  input  logic       i_carry,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  logic w_is_nine;

  assign w_is_nine = (i_digit == 4'd9);
  assign o_carry   = i_carry & w_is_nine;
  assign o_digit   = !i_carry  ? i_digit :
                     w_is_nine ? 4'd0    : i_digit + 4'd1;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : score_keeper                                                |
// | Purpose  : Runner-game score keeper: BCD score driven by game ticks,   |
// |            hi-score capture at game end, milestone flash and a         |
// |            registered glyph lookup for the score renderer.             |
// | Ports    : clk  in  1  system clock                                    |
// |            rst  in  1  asynchronous active-low reset                   |
// |            bus  slave modport of score_keeper_if (game events in,      |
// |                 slot in, glyph/score/hi_score/flash out)               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int DIGITS      = 5,
  parameter int TICK_DIV    = 6,
  parameter int FLASH_TICKS = 32
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  bus
);

  localparam int SCORE_W = 4 * DIGITS;
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Bit 2 of the flash counter drives the blink, so keep at least 3 bits.
  localparam int FLASH_W = ($clog2(FLASH_TICKS) > 3) ? $clog2(FLASH_TICKS) : 3;
  localparam int LOW_W   = (DIGITS >= 2) ? 8 : 4;

  localparam logic [TICK_W-1:0]  TICK_LAST       = TICK_W'(TICK_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST      = FLASH_W'(FLASH_TICKS - 1);
  localparam logic [3:0]         SLOT_SCORE_BASE = slot_score_base(DIGITS);

  // Reset: assert asynchronously, release synchronously.
  logic [1:0]         r_rst_sync;
  logic               w_rst_n;

  state_t             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_hi;
  logic [TICK_W-1:0]  r_tick;
  logic [FLASH_W-1:0] r_flash_cnt;
  logic               r_flash;
  logic [3:0]         r_glyph;

  logic [SCORE_W-1:0] w_score_inc;
  logic [DIGITS:0]    w_carry;
  logic               w_saturated;
  logic               w_milestone;
  logic [SCORE_W-1:0] w_hi_next;
  logic               w_blank;
  logic [3:0]         w_glyph_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // BCD ripple incrementer: score + 1.
  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_inc u_inc (
        .i_digit (r_score[4*gi +: 4]),
        .i_carry (w_carry[gi]),
        .o_digit (w_score_inc[4*gi +: 4]),
        .o_carry (w_carry[gi+1])
      );
    end
  endgenerate

  // A carry out of the top digit means the score is all 9s: hold it there.
  assign w_saturated = w_carry[DIGITS];
  assign w_milestone = !w_saturated && (w_score_inc[LOW_W-1:0] == '0);

  // Packed BCD orders the same as the decimal value it encodes.
  assign w_hi_next = (r_score > r_hi) ? r_score : r_hi;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_hi        <= '0;
      r_tick      <= '0;
      r_flash_cnt <= '0;
      r_flash     <= 1'b0;
    end else if (bus.restart) begin
      // Restart beats a simultaneous game_over and works from any state.
      r_hi        <= w_hi_next;
      r_score     <= '0;
      r_tick      <= '0;
      r_flash_cnt <= '0;
      r_flash     <= 1'b0;
      r_state     <= ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_score <= '0;
          if (bus.run) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (bus.game_over) begin
            r_hi        <= w_hi_next;
            r_flash     <= 1'b0;
            r_flash_cnt <= '0;
            r_state     <= ST_OVER;
          end else if (bus.game_tick) begin
            if (r_flash) begin
              if (r_flash_cnt == FLASH_LAST) begin
                r_flash     <= 1'b0;
                r_flash_cnt <= '0;
              end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
              end
            end
            if (r_tick == TICK_LAST) begin
              r_tick <= '0;
              if (!w_saturated) begin
                r_score <= w_score_inc;
                // A fresh milestone restarts the window (overrides aging above).
                if (w_milestone) begin
                  r_flash     <= 1'b1;
                  r_flash_cnt <= '0;
                end
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end

        ST_OVER: begin
          // Everything frozen until restart.
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Glyph lookup; blanking applies to score digits only.
  assign w_blank = r_flash & r_flash_cnt[2];

  always_comb begin
    w_glyph_next = GLYPH_BLANK;
    if (bus.slot == SLOT_H) begin
      w_glyph_next = GLYPH_H;
    end else if (bus.slot == SLOT_I) begin
      w_glyph_next = GLYPH_I;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        // Digit k counts from the LSD; slots list the MSD first.
        if (bus.slot == 4'(int'(SLOT_HI_BASE) + DIGITS - 1 - k)) begin
          w_glyph_next = r_hi[4*k +: 4];
        end
        if (bus.slot == 4'(int'(SLOT_SCORE_BASE) + DIGITS - 1 - k)) begin
          w_glyph_next = w_blank ? GLYPH_BLANK : r_score[4*k +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_glyph <= GLYPH_BLANK;
    end else begin
      r_glyph <= w_glyph_next;
    end
  end

  assign bus.glyph    = r_glyph;
  assign bus.score    = r_score;
  assign bus.hi_score = r_hi;
  assign bus.flash    = r_flash;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_score_keeper                                             |
// | Purpose  : Self-checking bench for score_keeper. A decimal reference   |
// |            model tracks mode, score, hi-score, tick phase and flash    |
// |            age; outputs are compared every cycle with random slots.    |
// |            A second 2-digit instance covers score saturation.          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_score_keeper;

  localparam int D    = 5;
  localparam int TD   = 6;
  localparam int FT   = 32;
  localparam int MAXS = 99999;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  score_keeper_if #(.DIGITS(D)) bus ();
  score_keeper_if #(.DIGITS(2)) sbus ();

  score_keeper #(.DIGITS(D), .TICK_DIV(TD), .FLASH_TICKS(FT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  score_keeper #(.DIGITS(2), .TICK_DIV(2), .FLASH_TICKS(8)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int    n_cmp  = 0;
  int    n_fail = 0;
  string phase  = "init";

  // Reference model (decimal values, not BCD).
  int m_mode, m_score, m_hi, m_sub, m_age;
  bit m_flash;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int digit_of(input int v, input int k);
    int t;
    t = v;
    for (int i = 0; i < k; i++) t = t / 10;
    return t % 10;
  endfunction

  function automatic logic [3:0] model_glyph(input int sl);
    if (sl == 0) return 4'd10;
    if (sl == 1) return 4'd11;
    if (sl >= 2 && sl < 2 + D) return 4'(digit_of(m_hi, D - 1 - (sl - 2)));
    if (sl >= 2 + D && sl < 2 + 2 * D) begin
      if (m_flash && (((m_age >> 2) & 1) == 1)) return 4'd15;
      return 4'(digit_of(m_score, D - 1 - (sl - 2 - D)));
    end
    return 4'd15;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_score = 0;
    m_hi    = 0;
    m_sub   = 0;
    m_age   = 0;
    m_flash = 1'b0;
  endtask

  task automatic model_update(input bit gt, input bit rn, input bit go, input bit rs);
    if (rs) begin
      if (m_score > m_hi) m_hi = m_score;
      m_score = 0;
      m_sub   = 0;
      m_flash = 1'b0;
      m_age   = 0;
      m_mode  = M_RUN;
    end else if (m_mode == M_IDLE) begin
      if (rn) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (go) begin
        if (m_score > m_hi) m_hi = m_score;
        m_flash = 1'b0;
        m_mode  = M_OVER;
      end else if (gt) begin
        if (m_flash) begin
          m_age++;
          if (m_age >= FT) m_flash = 1'b0;
        end
        m_sub++;
        if (m_sub == TD) begin
          m_sub = 0;
          if (m_score < MAXS) begin
            m_score++;
            if (m_score % 100 == 0) begin
              m_flash = 1'b1;
              m_age   = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
      $error("%s/%s observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rand_slot();
    return 4'($urandom_range(0, 15));
  endfunction

  // One clock cycle on the main instance: drive, advance model, compare.
  task automatic step(input bit gt, input bit rn, input bit go, input bit rs,
                      input logic [3:0] sl);
    logic [3:0] eg;
    @(negedge clk);
    bus.game_tick = gt;
    bus.run       = rn;
    bus.game_over = go;
    bus.restart   = rs;
    bus.slot      = sl;
    eg = model_glyph(int'(sl));
    model_update(gt, rn, go, rs);
    @(posedge clk);
    #1;
    check("glyph", 32'(bus.glyph), 32'(eg));
    check("score", 32'(bus.score), to_bcd(m_score));
    check("hi",    32'(bus.hi_score), to_bcd(m_hi));
    check("flash", 32'(bus.flash), 32'(m_flash));
    bus.game_tick = 1'b0;
    bus.run       = 1'b0;
    bus.game_over = 1'b0;
    bus.restart   = 1'b0;
  endtask

  task automatic tick(input bit gaps);
    step(1'b1, 1'b0, 1'b0, 1'b0, rand_slot());
    if (gaps) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 1'b0, rand_slot());
    end
  endtask

  task automatic run_to(input int target, input bit gaps);
    while (m_score < target) tick(gaps);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [3:0] sweep_exp [16];

  initial begin
    sweep_exp = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0,
                  4'd0, 4'd0, 4'd5, 4'd6, 4'd15, 4'd15, 4'd15, 4'd15};
    bus.game_tick  = 1'b0;
    bus.run        = 1'b0;
    bus.game_over  = 1'b0;
    bus.restart    = 1'b0;
    bus.slot       = 4'd0;
    sbus.game_tick = 1'b0;
    sbus.run       = 1'b0;
    sbus.game_over = 1'b0;
    sbus.restart   = 1'b0;
    sbus.slot      = 4'd0;
    model_reset();

    // Reset values.
    phase = "reset";
    repeat (3) @(negedge clk);
    check("score", 32'(bus.score), 32'h0);
    check("hi",    32'(bus.hi_score), 32'h0);
    check("flash", 32'(bus.flash), 32'h0);
    check("glyph", 32'(bus.glyph), 32'd15);
    check("sat_glyph", 32'(sbus.glyph), 32'd15);
    release_reset();

    // IDLE ignores ticks; run starts the game.
    phase = "idle";
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, rand_slot());
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_slot());

    // 600 ticks -> 100, milestone flash, hi still 0; then through the window.
    phase = "ticks600";
    repeat (600) tick(1'b1);
    check("score100", 32'(bus.score), 32'h00100);
    check("flash_on", 32'(bus.flash), 32'h1);
    check("hi_zero",  32'(bus.hi_score), 32'h0);
    repeat (40) tick(1'b1);

    // Restart mid-game, climb to 42, then asynchronous reset.
    phase = "restart";
    step(1'b0, 1'b0, 1'b0, 1'b1, rand_slot());
    run_to(42, 1'b1);
    phase = "async_rst";
    check("score42", 32'(bus.score), 32'h00042);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("score", 32'(bus.score), 32'h0);
    check("hi",    32'(bus.hi_score), 32'h0);
    check("flash", 32'(bus.flash), 32'h0);
    check("glyph", 32'(bus.glyph), 32'd15);
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
    phase = "idle2";
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, rand_slot());
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_slot());

    // 00099, then game_over together with an incrementing tick.
    phase = "over_tie";
    run_to(99, 1'b0);
    repeat (5) tick(1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, rand_slot());
    check("score99", 32'(bus.score), 32'h00099);
    check("hi99",    32'(bus.hi_score), 32'h00099);
    phase = "over_frozen";
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, rand_slot());
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_slot());

    // hi 150 survives a lower game; restart overrides game_over.
    phase = "hi_keep";
    step(1'b0, 1'b0, 1'b0, 1'b1, rand_slot());
    run_to(150, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_slot());
    step(1'b0, 1'b0, 1'b0, 1'b1, rand_slot());
    run_to(120, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_slot());
    check("hi150", 32'(bus.hi_score), 32'h00150);
    step(1'b0, 1'b0, 1'b1, 1'b1, rand_slot());
    check("restart_score", 32'(bus.score), 32'h0);
    repeat (6) tick(1'b0);
    check("running", 32'(bus.score), 32'h00001);

    // Slot sweep with hi 01234 and score 00056.
    phase = "sweep";
    run_to(1234, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_slot());
    step(1'b0, 1'b0, 1'b0, 1'b1, rand_slot());
    run_to(56, 1'b0);
    for (int s = 0; s < 16; s++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'(s));
      check($sformatf("slot%0d", s), 32'(bus.glyph), 32'(sweep_exp[s]));
    end

    // Saturation on the 2-digit instance (TICK_DIV 2): 99 then 12 more points.
    phase = "saturate";
    @(negedge clk);
    sbus.run = 1'b1;
    @(negedge clk);
    sbus.run = 1'b0;
    for (int i = 1; i <= 222; i++) begin
      @(negedge clk);
      sbus.game_tick = 1'b1;
      @(posedge clk);
      #1;
      sbus.game_tick = 1'b0;
      if (i == 20)  check("sat10", 32'(sbus.score), 32'h10);
      if (i == 198) check("sat99", 32'(sbus.score), 32'h99);
    end
    check("sat_hold",  32'(sbus.score), 32'h99);
    check("sat_flash", 32'(sbus.flash), 32'h0);
    @(negedge clk);
    sbus.game_over = 1'b1;
    @(posedge clk);
    #1;
    sbus.game_over = 1'b0;
    check("sat_hi", 32'(sbus.hi_score), 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached in phase %s", phase);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
